// File: rtl/sp_lane_pipe.sv
// Per-thread SP lane pipeline: ID/EX -> EX (external exec handshake) -> MEM -> WB.
// Define SP_LANE_FWD_EN to bypass EX/MEM and MEM/WB results into the ID operand reads.
module sp_lane_pipe #(
    parameter int DW = 16,
    parameter int NREG = 16,
    parameter int NEXTW = 3,
    parameter logic [DW-1:0] TID = '0,
    localparam int AW = $clog2(NREG),
    localparam int NE = (NEXTW > 0) ? NEXTW : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush_id,
    input  logic              id_valid,
    input  logic              id_active,
    input  logic              id_rf_we,
    input  logic              id_pred_we,
    input  logic              id_use_imm,
    input  logic              id_sel_tid,
    input  logic [AW-1:0]     id_rs0,
    input  logic [AW-1:0]     id_rs1,
    input  logic [AW-1:0]     id_rs2,
    input  logic [AW-1:0]     id_rd,
    input  logic [1:0]        id_pred_rd_sel,
    input  logic [1:0]        id_pred_wr_sel,
    input  logic [7:0]        id_op,
    input  logic [1:0]        id_wb_src,
    input  logic [DW-1:0]     id_imm,
    output logic              ex_req_valid,
    output logic [7:0]        ex_req_op,
    output logic [DW-1:0]     ex_req_a,
    output logic [DW-1:0]     ex_req_b,
    output logic [DW-1:0]     ex_req_c,
    output logic              ex_req_pred,
    input  logic              ex_rsp_valid,
    input  logic [DW-1:0]     ex_rsp_data,
    input  logic              ex_rsp_cmp,
    output logic              ex_busy,
    output logic [DW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic              mem_is_load,
    output logic              mem_is_store,
    input  logic [DW-1:0]     mem_rdata,
    input  logic [NE-1:0]     ext_we,
    input  logic [NE*AW-1:0]  ext_addr,
    input  logic [NE*DW-1:0]  ext_data,
    output logic              wb_valid,
    output logic              wb_rf_we,
    output logic              wb_active,
    output logic [AW-1:0]     wb_rd,
    output logic [31:0]       retired
);
    // Handshake: ex_req_valid is a single-cycle pulse in IDLE; ex_rsp_valid is
    // honoured only in WAIT and always arrives at least one cycle after the request.
    typedef enum logic {S_IDLE, S_WAIT} ex_state_t;
    ex_state_t state;

    logic [DW-1:0] gpr [NREG];
    logic [3:0]    pred;

    logic          ie_valid, ie_active, ie_rf_we, ie_pred_we, ie_pred;
    logic [1:0]    ie_wb_src, ie_pwsel;
    logic [AW-1:0] ie_rd;
    logic [7:0]    ie_op;
    logic [DW-1:0] ie_a, ie_b, ie_c;

    logic          em_valid, em_active, em_rf_we, em_pred_we, em_cmp;
    logic [1:0]    em_wb_src, em_pwsel;
    logic [AW-1:0] em_rd;
    logic [DW-1:0] em_res, em_sd;

    logic          mw_valid, mw_active, mw_rf_we, mw_pred_we, mw_cmp;
    logic [1:0]    mw_wb_src, mw_pwsel;
    logic [AW-1:0] mw_rd;
    logic [DW-1:0] mw_res;

    logic [DW-1:0] wb_data, src0, src1, src2;
    logic          w0_we, pw_we;

    assign wb_data = (mw_wb_src == 2'd1) ? mem_rdata : mw_res;
    assign w0_we   = mw_valid & mw_rf_we & mw_active & ~stall;
    assign pw_we   = mw_valid & mw_pred_we & mw_active & ~stall;

`ifdef SP_LANE_FWD_EN
    // Loads are excluded from the EX/MEM bypass: their data only exists in WB.
    logic em_fwd, mw_fwd;
    assign em_fwd = em_valid & em_rf_we & em_active & (em_wb_src == 2'd0);
    assign mw_fwd = mw_valid & mw_rf_we & mw_active;
    assign src0 = (em_fwd && em_rd == id_rs0) ? em_res : (mw_fwd && mw_rd == id_rs0) ? wb_data : gpr[id_rs0];
    assign src1 = (em_fwd && em_rd == id_rs1) ? em_res : (mw_fwd && mw_rd == id_rs1) ? wb_data : gpr[id_rs1];
    assign src2 = (em_fwd && em_rd == id_rs2) ? em_res : (mw_fwd && mw_rd == id_rs2) ? wb_data : gpr[id_rs2];
`else
    assign src0 = gpr[id_rs0];
    assign src1 = gpr[id_rs1];
    assign src2 = gpr[id_rs2];
`endif

    assign ex_req_valid = (state == S_IDLE) & ie_valid;
    assign ex_busy      = ex_req_valid | (state == S_WAIT);
    assign ex_req_op    = ie_op;
    assign ex_req_a     = ie_a;
    assign ex_req_b     = ie_b;
    assign ex_req_c     = ie_c;
    assign ex_req_pred  = ie_pred;

    assign mem_addr     = em_res;
    assign mem_wdata    = em_sd;
    assign mem_is_load  = em_valid & (em_wb_src == 2'd1);
    assign mem_is_store = em_valid & (em_wb_src == 2'd2);

    assign wb_valid  = mw_valid;
    assign wb_rf_we  = mw_valid & mw_rf_we;
    assign wb_active = mw_active;
    assign wb_rd     = mw_rd;

    // Register files: later assignments win, so ascending external ports override W0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) gpr[i] <= '0;
            pred <= '0;
        end else begin
            if (w0_we) gpr[mw_rd] <= wb_data;
            for (int i = 0; i < NEXTW; i++)
                if (ext_we[i]) gpr[ext_addr[i*AW +: AW]] <= ext_data[i*DW +: DW];
            if (pw_we) pred[mw_pwsel] <= mw_cmp;
        end
    end

    // ID/EX: valid drops once the request is issued so a held slot never re-issues.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ie_valid <= 1'b0; ie_active <= 1'b0; ie_rf_we <= 1'b0; ie_pred_we <= 1'b0;
            ie_pred <= 1'b0; ie_wb_src <= '0; ie_pwsel <= '0; ie_rd <= '0; ie_op <= '0;
            ie_a <= '0; ie_b <= '0; ie_c <= '0;
        end else if (!stall) begin
            ie_valid   <= id_valid & ~flush_id;
            ie_rf_we   <= id_rf_we & ~flush_id;
            ie_pred_we <= id_pred_we & ~flush_id;
            ie_active  <= id_active;
            ie_pred    <= pred[id_pred_rd_sel];
            ie_wb_src  <= id_wb_src;
            ie_pwsel   <= id_pred_wr_sel;
            ie_rd      <= id_rd;
            ie_op      <= id_op;
            ie_a       <= id_sel_tid ? TID : src0;
            ie_b       <= id_use_imm ? id_imm : src1;
            ie_c       <= src2;
        end else if (ex_req_valid) begin
            ie_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (ie_valid) state <= S_WAIT;
                S_WAIT:  if (ex_rsp_valid) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // EX/MEM takes a response even under stall; it then holds until the stall lifts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            em_valid <= 1'b0; em_active <= 1'b0; em_rf_we <= 1'b0; em_pred_we <= 1'b0;
            em_cmp <= 1'b0; em_wb_src <= '0; em_pwsel <= '0; em_rd <= '0;
            em_res <= '0; em_sd <= '0;
        end else if (state == S_WAIT && ex_rsp_valid) begin
            em_valid   <= 1'b1;
            em_active  <= ie_active;
            em_rf_we   <= ie_rf_we;
            em_pred_we <= ie_pred_we;
            em_cmp     <= ex_rsp_cmp;
            em_wb_src  <= ie_wb_src;
            em_pwsel   <= ie_pwsel;
            em_rd      <= ie_rd;
            em_res     <= ex_rsp_data;
            em_sd      <= ie_c;
        end else if (!stall) begin
            em_valid   <= 1'b0;
            em_rf_we   <= 1'b0;
            em_pred_we <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mw_valid <= 1'b0; mw_active <= 1'b0; mw_rf_we <= 1'b0; mw_pred_we <= 1'b0;
            mw_cmp <= 1'b0; mw_wb_src <= '0; mw_pwsel <= '0; mw_rd <= '0; mw_res <= '0;
            retired <= '0;
        end else if (!stall) begin
            mw_valid   <= em_valid;
            mw_active  <= em_active;
            mw_rf_we   <= em_rf_we;
            mw_pred_we <= em_pred_we;
            mw_cmp     <= em_cmp;
            mw_wb_src  <= em_wb_src;
            mw_pwsel   <= em_pwsel;
            mw_rd      <= em_rd;
            mw_res     <= em_res;
            if (mw_valid && mw_active) retired <= retired + 32'd1;
        end
    end
endmodule
